// File: rtl/eth_frame_gen_stream_if.sv
// Byte-wide valid/ready stream carrying Ethernet frames with start/end markers.
interface eth_frame_gen_stream_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sof;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_sof, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_sof, input m_last, output m_ready);
endinterface

// File: rtl/eth_frame_gen_stream.sv
// Ethernet frame source: optional preamble/SFD, header from ports, pattern payload with
// zero padding and a byte-serial IEEE 802.3 CRC-32 FCS, followed by an inter-frame gap.
module eth_frame_gen_stream #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int PREAMBLE_EN = 1,
  parameter int IFG_CYCLES  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [47:0]           cfg_dst_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [15:0]           cfg_eth_type,
  input  logic [10:0]           cfg_payload_len,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_seed,
  eth_frame_gen_stream_if.master m,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_PAD  = 3'd5;
  localparam logic [2:0] S_FCS  = 3'd6;
  localparam logic [2:0] S_IFG  = 3'd7;

  localparam logic [10:0] MAX_LEN     = 11'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST    = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [2:0]  S_FIRST     = (PREAMBLE_EN != 0) ? S_PRE : S_HDR;
  localparam logic [2:0]  S_AFTER_FCS = (IFG_CYCLES > 0) ? S_IFG : S_IDLE;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] d);
    logic [31:0] c;
    c = crc_in ^ {24'd0, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] pat_step(input logic [7:0] p, input logic [1:0] md);
    case (md)
      2'd0:    pat_step = p + 8'd1;
      2'd2:    pat_step = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
      default: pat_step = p;
    endcase
  endfunction

  logic [2:0]   state, state_next;
  logic [10:0]  cnt, cnt_next, len, pad_last;
  logic [7:0]   pat, pat_next, pat_init, seed;
  logic [31:0]  crc, crc_next, fcs;
  logic [15:0]  ifg_cnt, eth_type;
  logic [47:0]  dst, src;
  logic [1:0]   mode;
  logic [111:0] hdr;
  logic [7:0]   data, data_next;
  logic         valid, sof, last, hs;
  logic         valid_next, sof_next, last_next, busy_next;

  assign m.m_data  = data;
  assign m.m_valid = valid;
  assign m.m_sof   = sof;
  assign m.m_last  = last;

  // Next position in the frame and the byte presented at that position.
  always_comb begin
    hs         = valid && m.m_ready;
    state_next = state;
    cnt_next   = cnt;
    pat_next   = pat;
    crc_next   = crc;
    pad_last   = 11'd45 - len;
    pat_init   = ((mode == 2'd2) && (seed == 8'd0)) ? 8'h01 : seed;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
        else       state_next = S_IDLE;
      end
      S_LOAD: begin
        state_next = S_FIRST;
        cnt_next   = 11'd0;
      end
      S_PRE: begin
        if (hs && (cnt == 11'd7)) begin
          state_next = S_HDR;
          cnt_next   = 11'd0;
        end else if (hs) cnt_next = cnt + 11'd1;
        else             cnt_next = cnt;
      end
      S_HDR: begin
        if (hs) begin
          crc_next = crc32_byte(crc, data);
          if (cnt == 11'd13) begin
            state_next = (len == 11'd0) ? S_PAD : S_PAY;
            cnt_next   = 11'd0;
            pat_next   = pat_init;
          end else cnt_next = cnt + 11'd1;
        end else crc_next = crc;
      end
      S_PAY: begin
        if (hs) begin
          crc_next = crc32_byte(crc, data);
          pat_next = pat_step(pat, mode);
          if (cnt == len - 11'd1) begin
            state_next = (len < 11'd46) ? S_PAD : S_FCS;
            cnt_next   = 11'd0;
          end else cnt_next = cnt + 11'd1;
        end else crc_next = crc;
      end
      S_PAD: begin
        if (hs) begin
          crc_next = crc32_byte(crc, data);
          if (cnt == pad_last) begin
            state_next = S_FCS;
            cnt_next   = 11'd0;
          end else cnt_next = cnt + 11'd1;
        end else crc_next = crc;
      end
      S_FCS: begin
        if (hs && (cnt == 11'd3)) begin
          state_next = S_AFTER_FCS;
          cnt_next   = 11'd0;
          crc_next   = 32'hFFFFFFFF;
        end else if (hs) cnt_next = cnt + 11'd1;
        else             cnt_next = cnt;
      end
      S_IFG: begin
        if (ifg_cnt == IFG_LAST) state_next = S_IDLE;
        else                     state_next = S_IFG;
      end
      default: state_next = S_IDLE;
    endcase

    // FCS byte 0 must already include the last PAD/PAYLOAD byte, hence crc_next.
    hdr = {dst, src, eth_type};
    fcs = ~crc_next;
    case (state_next)
      S_PRE:   data_next = (cnt_next == 11'd7) ? 8'hD5 : 8'h55;
      S_HDR:   data_next = 8'(hdr >> (7'd104 - {cnt_next[3:0], 3'b000}));
      S_PAY:   data_next = pat_next;
      S_FCS:   data_next = 8'(fcs >> {cnt_next[1:0], 3'b000});
      default: data_next = 8'h00;
    endcase
    valid_next = state_next inside {S_PRE, S_HDR, S_PAY, S_PAD, S_FCS};
    sof_next   = (state == S_LOAD) || (sof && !hs);
    last_next  = (state_next == S_FCS) && (cnt_next == 11'd3);
    busy_next  = !((state_next == S_IDLE) || (state_next == S_LOAD));
  end

  // State, output and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 11'd0;
      pat       <= 8'd0;
      crc       <= 32'hFFFFFFFF;
      ifg_cnt   <= 16'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      sof       <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 16'd0;
      dst       <= 48'd0;
      src       <= 48'd0;
      eth_type  <= 16'd0;
      len       <= 11'd0;
      mode      <= 2'd0;
      seed      <= 8'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pat     <= pat_next;
      crc     <= crc_next;
      data    <= data_next;
      valid   <= valid_next;
      sof     <= sof_next;
      last    <= last_next;
      busy    <= busy_next;
      done    <= hs && last;
      ifg_cnt <= (state == S_IFG) ? ifg_cnt + 16'd1 : 16'd0;
      if (hs && last) frame_cnt <= frame_cnt + 16'd1;
      else            frame_cnt <= frame_cnt;
      if ((state == S_IDLE) && start) begin
        dst      <= cfg_dst_mac;
        src      <= cfg_src_mac;
        eth_type <= cfg_eth_type;
        len      <= (cfg_payload_len > MAX_LEN) ? MAX_LEN : cfg_payload_len;
        mode     <= cfg_mode;
        seed     <= cfg_seed;
      end else begin
        dst      <= dst;
        src      <= src;
        eth_type <= eth_type;
        len      <= len;
        mode     <= mode;
        seed     <= seed;
      end
    end
  end

endmodule
